// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit for the execute stage.
//   Multiply: radix-2 shift-add on operand magnitudes, one bit per cycle.
//   Divide:   restoring division on magnitudes, one quotient bit per cycle.
//   Divide by zero and signed overflow finish without iterating.
// Optional build macro: MULDIV_FAST_MUL_EN -- single-cycle combinational
//   multiply in the MUL state; divides are unchanged.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start             request, sampled only when idle
//   funct3            M-op select (MUL..REMU)
//   rs1_data/rs2_data operand A / operand B
//   flush             abort the current operation
//   busy              high while an operation occupies the unit
//   done              one-cycle strobe, result valid
//   result            result register, held until the next completion
module muldiv_unit #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int unsigned CW = $clog2(XLEN);
  localparam int unsigned PW = 2 * XLEN;
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t state, state_nxt;

  logic [1:0]      op_sel;   // funct3[1:0] of the accepted op
  logic            op_neg;   // product / quotient sign
  logic            rem_neg;  // remainder sign
  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] opnd;     // multiplicand or divisor magnitude
  logic [XLEN-1:0] acc_hi;   // product high half / partial remainder
  logic [XLEN-1:0] acc_lo;   // product low half (multiplier) / dividend-quotient

  logic            capture, step, load_res;
  logic [XLEN-1:0] res_nxt;

  // Operand signedness, signs and magnitudes at capture
  logic            a_signed, b_signed, a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;

  always_comb begin
    if (funct3[2]) begin
      a_signed = ~funct3[0];
      b_signed = ~funct3[0];
    end else begin
      a_signed = (funct3[1:0] != 2'b11);
      b_signed = ~funct3[1];
    end
    a_neg = a_signed & rs1_data[XLEN-1];
    b_neg = b_signed & rs2_data[XLEN-1];
    a_mag = a_neg ? -rs1_data : rs1_data;
    b_mag = b_neg ? -rs2_data : rs2_data;
  end

  // Divide special cases resolved directly from the inputs
  logic            div_by_zero, div_ovf;
  logic [XLEN-1:0] special_res;

  always_comb begin
    div_by_zero = (rs2_data == '0);
    div_ovf     = ~funct3[0] & (rs1_data == MIN_NEG) & (&rs2_data);
    if (div_by_zero) special_res = funct3[1] ? rs1_data : '1;
    else             special_res = funct3[1] ? '0 : rs1_data;
  end

  // Multiply: next product value (one shift-add step, or the whole product)
  logic [PW-1:0]   mul_prod_nxt;
  logic [PW-1:0]   mul_prod_s;
  logic [XLEN-1:0] mul_res;
  logic            mul_last;

`ifdef MULDIV_FAST_MUL_EN
  always_comb begin
    mul_prod_nxt = PW'(opnd) * PW'(acc_lo);
    mul_last     = 1'b1;
  end
`else
  logic [XLEN:0] mul_sum;

  always_comb begin
    mul_sum      = {1'b0, acc_hi} + {1'b0, (acc_lo[0] ? opnd : '0)};
    mul_prod_nxt = {mul_sum, acc_lo[XLEN-1:1]};
    mul_last     = (cnt == '0);
  end
`endif

  always_comb begin
    mul_prod_s = op_neg ? -mul_prod_nxt : mul_prod_nxt;
    mul_res    = (op_sel == 2'b00) ? mul_prod_s[XLEN-1:0] : mul_prod_s[PW-1:XLEN];
  end

  // Divide: one restoring step; partial remainder always below the divisor
  logic [XLEN:0]   div_part;
  logic [XLEN-1:0] div_diff, div_q_nxt, div_r_nxt, div_res;
  logic            div_ge;

  always_comb begin
    div_part  = {acc_hi, acc_lo[XLEN-1]};
    div_ge    = (div_part >= {1'b0, opnd});
    div_diff  = div_part[XLEN-1:0] - opnd;
    div_q_nxt = {acc_lo[XLEN-2:0], div_ge};
    div_r_nxt = div_ge ? div_diff : div_part[XLEN-1:0];
    if (op_sel[1]) div_res = rem_neg ? -div_r_nxt : div_r_nxt;
    else           div_res = op_neg  ? -div_q_nxt : div_q_nxt;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next state and datapath control; flush overrides everything
  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    step      = 1'b0;
    load_res  = 1'b0;
    res_nxt   = '0;
    case (state)
      S_IDLE: begin
        if (start) begin
          capture = 1'b1;
          if (!funct3[2]) begin
            state_nxt = S_MUL;
          end else if (div_by_zero || div_ovf) begin
            state_nxt = S_DONE;
            load_res  = 1'b1;
            res_nxt   = special_res;
          end else begin
            state_nxt = S_DIV;
          end
        end
      end
      S_MUL: begin
        step = 1'b1;
        if (mul_last) begin
          state_nxt = S_DONE;
          load_res  = 1'b1;
          res_nxt   = mul_res;
        end
      end
      S_DIV: begin
        step = 1'b1;
        if (cnt == '0) begin
          state_nxt = S_DONE;
          load_res  = 1'b1;
          res_nxt   = div_res;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (flush) begin
      state_nxt = S_IDLE;
      capture   = 1'b0;
      step      = 1'b0;
      load_res  = 1'b0;
    end
  end

  // Datapath registers and registered status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      op_sel  <= '0;
      op_neg  <= 1'b0;
      rem_neg <= 1'b0;
      cnt     <= '0;
      opnd    <= '0;
      acc_hi  <= '0;
      acc_lo  <= '0;
      result  <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      busy <= (state_nxt != S_IDLE);
      done <= (state_nxt == S_DONE);
      if (capture) begin
        op_sel  <= funct3[1:0];
        op_neg  <= a_neg ^ b_neg;
        rem_neg <= a_neg;
        cnt     <= CW'(XLEN - 1);
        acc_hi  <= '0;
        if (!funct3[2]) begin
          opnd   <= a_mag;
          acc_lo <= b_mag;
        end else begin
          opnd   <= b_mag;
          acc_lo <= a_mag;
        end
      end else if (step) begin
        cnt <= cnt - CW'(1);
        if (state == S_DIV) {acc_hi, acc_lo} <= {div_r_nxt, div_q_nxt};
        else                {acc_hi, acc_lo} <= mul_prod_nxt;
      end
      if (load_res) result <= res_nxt;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed testbench for muldiv_unit: result values, done latency, busy
// window, special cases, ignored start, flush, mid-op reset, back-to-back.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int cmp_cnt  = 0;
  int fail_cnt = 0;

`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_DONE = 2;
`else
  localparam int MUL_DONE = 33;
`endif
  localparam int DIV_DONE = 33;

  muldiv_unit #(.XLEN(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .funct3   (funct3),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .flush    (flush),
    .busy     (busy),
    .done     (done),
    .result   (result)
  );

  always #5 clk = ~clk;

  // Issue one op in cycle 0, return the cycle done was seen and the result
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        output int dcyc, output logic [31:0] res);
    @(negedge clk);
    start = 1'b1; funct3 = f; rs1_data = a; rs2_data = b;
    dcyc = -1;
    res  = 'x;
    for (int c = 1; c <= 45; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (done === 1'b1) begin
        dcyc = c;
        res  = result;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; flush = 1'b0;
    funct3 = 3'b000; rs1_data = '0; rs2_data = '0;
    repeat (3) @(negedge clk);
    cmp_cnt++; if (busy !== 1'b0) begin fail_cnt++; $display("FAIL reset_busy got %b want 0", busy); end
    cmp_cnt++; if (done !== 1'b0) begin fail_cnt++; $display("FAIL reset_done got %b want 0", done); end
    cmp_cnt++; if (result !== 32'h0) begin fail_cnt++; $display("FAIL reset_result got %h want 00000000", result); end
    rst = 1'b0;
  endtask

  task automatic test_mul();
    int busy_bad = 0, done_cnt = 0, first_done = -1;
    logic [31:0] got = 'x;
    @(negedge clk);
    start = 1'b1; funct3 = 3'b000; rs1_data = 32'h0000_0007; rs2_data = 32'hFFFF_FFFD;
    for (int c = 1; c <= 36; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c <= MUL_DONE && busy !== 1'b1) busy_bad++;
      if (c >  MUL_DONE && busy !== 1'b0) busy_bad++;
      if (done === 1'b1) begin
        done_cnt++;
        if (first_done < 0) begin first_done = c; got = result; end
      end
    end
    cmp_cnt++; if (got !== 32'hFFFF_FFEB) begin fail_cnt++; $display("FAIL mul_result got %h want ffffffeb", got); end
    cmp_cnt++; if (first_done != MUL_DONE) begin fail_cnt++; $display("FAIL mul_done_cycle got %0d want %0d", first_done, MUL_DONE); end
    cmp_cnt++; if (done_cnt != 1) begin fail_cnt++; $display("FAIL mul_done_pulses got %0d want 1", done_cnt); end
    cmp_cnt++; if (busy_bad != 0) begin fail_cnt++; $display("FAIL mul_busy_window got %0d bad cycles want 0", busy_bad); end
    cmp_cnt++; if (result !== 32'hFFFF_FFEB) begin fail_cnt++; $display("FAIL mul_result_hold got %h want ffffffeb", result); end
  endtask

  task automatic test_mul_high();
    logic [2:0]  f_t[3];
    logic [31:0] a_t[3], b_t[3], e_t[3];
    int d;
    logic [31:0] r;
    f_t = '{3'b001, 3'b011, 3'b010};
    a_t = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    b_t = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    e_t = '{32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF};
    for (int i = 0; i < 3; i++) begin
      run_op(f_t[i], a_t[i], b_t[i], d, r);
      cmp_cnt++; if (r !== e_t[i]) begin fail_cnt++; $display("FAIL mulh_result[%0d] got %h want %h", i, r, e_t[i]); end
      cmp_cnt++; if (d != MUL_DONE) begin fail_cnt++; $display("FAIL mulh_done_cycle[%0d] got %0d want %0d", i, d, MUL_DONE); end
    end
  endtask

  task automatic test_div();
    logic [2:0]  f_t[4];
    logic [31:0] a_t[4], e_t[4];
    int d;
    logic [31:0] r;
    f_t = '{3'b100, 3'b110, 3'b101, 3'b111};
    a_t = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'hFFFF_FFF9};
    e_t = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h7FFF_FFFC, 32'h0000_0001};
    for (int i = 0; i < 4; i++) begin
      run_op(f_t[i], a_t[i], 32'h0000_0002, d, r);
      cmp_cnt++; if (r !== e_t[i]) begin fail_cnt++; $display("FAIL div_result[%0d] got %h want %h", i, r, e_t[i]); end
      cmp_cnt++; if (d != DIV_DONE) begin fail_cnt++; $display("FAIL div_done_cycle[%0d] got %0d want %0d", i, d, DIV_DONE); end
    end
  endtask

  task automatic test_special();
    logic [2:0]  f_t[4];
    logic [31:0] a_t[4], b_t[4], e_t[4];
    int d;
    logic [31:0] r;
    f_t = '{3'b100, 3'b110, 3'b100, 3'b110};
    a_t = '{32'h0000_0005, 32'h0000_0005, 32'h8000_0000, 32'h8000_0000};
    b_t = '{32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    e_t = '{32'hFFFF_FFFF, 32'h0000_0005, 32'h8000_0000, 32'h0000_0000};
    for (int i = 0; i < 4; i++) begin
      run_op(f_t[i], a_t[i], b_t[i], d, r);
      cmp_cnt++; if (r !== e_t[i]) begin fail_cnt++; $display("FAIL special_result[%0d] got %h want %h", i, r, e_t[i]); end
      cmp_cnt++; if (d != 1) begin fail_cnt++; $display("FAIL special_done_cycle[%0d] got %0d want 1", i, d); end
    end
  endtask

  task automatic test_ignore_flush();
    int d, busy_bad = 0, done_at = -1;
    logic saw_done = 1'b0;
    logic [31:0] r, got = 'x;
    run_op(3'b110, 32'h0000_0005, 32'h0000_0000, d, r);  // result now 5
    @(negedge clk);
    start = 1'b1; funct3 = 3'b100; rs1_data = 32'd100; rs2_data = 32'd7;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      start = 1'b0;
      flush = 1'b0;
      if (c <= 11 && done === 1'b1) saw_done = 1'b1;
      if (c <= 10 && busy !== 1'b1) busy_bad++;
      if (c == 5) begin
        start = 1'b1; funct3 = 3'b000; rs1_data = 32'd9; rs2_data = 32'd3;
      end
      if (c == 10) flush = 1'b1;
      if (c == 11) begin
        cmp_cnt++; if (busy !== 1'b0) begin fail_cnt++; $display("FAIL flush_busy got %b want 0", busy); end
        cmp_cnt++; if (result !== 32'h5) begin fail_cnt++; $display("FAIL flush_result_hold got %h want 00000005", result); end
        start = 1'b1; funct3 = 3'b100; rs1_data = 32'd100; rs2_data = 32'd7;
      end
      if (c > 11 && done === 1'b1) begin
        done_at = c;
        got     = result;
        break;
      end
    end
    cmp_cnt++; if (saw_done !== 1'b0) begin fail_cnt++; $display("FAIL flush_no_done got %b want 0", saw_done); end
    cmp_cnt++; if (busy_bad != 0) begin fail_cnt++; $display("FAIL flush_busy_window got %0d bad cycles want 0", busy_bad); end
    cmp_cnt++; if (done_at != 44) begin fail_cnt++; $display("FAIL restart_done_cycle got %0d want 44", done_at); end
    cmp_cnt++; if (got !== 32'd14) begin fail_cnt++; $display("FAIL restart_result got %h want 0000000e", got); end
  endtask

  task automatic test_flush_start();
    @(negedge clk);
    start = 1'b1; flush = 1'b1; funct3 = 3'b100; rs1_data = 32'd5; rs2_data = 32'd0;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    cmp_cnt++; if (busy !== 1'b0) begin fail_cnt++; $display("FAIL flush_start_busy got %b want 0", busy); end
    cmp_cnt++; if (done !== 1'b0) begin fail_cnt++; $display("FAIL flush_start_done got %b want 0", done); end
    @(negedge clk);
    cmp_cnt++; if (result !== 32'd14) begin fail_cnt++; $display("FAIL flush_start_result got %h want 0000000e", result); end
  endtask

  task automatic test_rst_mid();
    int d;
    logic [31:0] r;
    @(negedge clk);
    start = 1'b1; funct3 = 3'b000; rs1_data = 32'd9; rs2_data = 32'd9;
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c == 15) rst = 1'b1;
    end
    @(negedge clk);
    rst = 1'b0;
    cmp_cnt++; if (busy !== 1'b0) begin fail_cnt++; $display("FAIL rst_mid_busy got %b want 0", busy); end
    cmp_cnt++; if (done !== 1'b0) begin fail_cnt++; $display("FAIL rst_mid_done got %b want 0", done); end
    cmp_cnt++; if (result !== 32'h0) begin fail_cnt++; $display("FAIL rst_mid_result got %h want 00000000", result); end
    run_op(3'b011, 32'hFFFF_FFFF, 32'h0000_0002, d, r);
    cmp_cnt++; if (r !== 32'h1) begin fail_cnt++; $display("FAIL rst_after_result got %h want 00000001", r); end
    cmp_cnt++; if (d != MUL_DONE) begin fail_cnt++; $display("FAIL rst_after_done_cycle got %0d want %0d", d, MUL_DONE); end
  endtask

  task automatic test_back_to_back();
    int done_at = -1;
    logic [31:0] got = 'x;
    @(negedge clk);
    start = 1'b1; funct3 = 3'b100; rs1_data = 32'd5; rs2_data = 32'd0;  // cycle 0
    @(negedge clk);                                                      // cycle 1: DONE
    cmp_cnt++; if (done !== 1'b1) begin fail_cnt++; $display("FAIL b2b_first_done got %b want 1", done); end
    cmp_cnt++; if (result !== 32'hFFFF_FFFF) begin fail_cnt++; $display("FAIL b2b_first_result got %h want ffffffff", result); end
    funct3 = 3'b101; rs1_data = 32'd20; rs2_data = 32'd0;                // start held in DONE: ignored
    @(negedge clk);                                                      // cycle 2: IDLE
    cmp_cnt++; if (done !== 1'b0) begin fail_cnt++; $display("FAIL b2b_start_in_done got %b want 0", done); end
    funct3 = 3'b111; rs1_data = 32'd20; rs2_data = 32'd3;
    for (int c = 3; c <= 45; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (done === 1'b1) begin
        done_at = c;
        got     = result;
        break;
      end
    end
    cmp_cnt++; if (done_at != 35) begin fail_cnt++; $display("FAIL b2b_second_done_cycle got %0d want 35", done_at); end
    cmp_cnt++; if (got !== 32'd2) begin fail_cnt++; $display("FAIL b2b_second_result got %h want 00000002", got); end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_mul_high();
    test_div();
    test_special();
    test_ignore_flush();
    test_flush_start();
    test_rst_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
    $finish;
  end

endmodule
